calc_key_entry: RTL and testbench
=================================

Name: calc_key_entry

Overview:
- Consumer end of the keypad cursor interface: takes the 5-bit key code of the selected cell plus a select strobe, and runs the calculator.
- Builds operands digit by digit, latches the operator, and computes on EXE.
- Drives `restriction` back to the cursor so digits A–F are unreachable in decimal mode.
- Sits between the grid cursor and the display driver.

Parameters:
- NDIG, 4, maximum digits per operand; operand/result width W = 4*NDIG (default 16).

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- key_val  in  5  key code from cursor: 0x00–0x0F digit, 0x10 ADD, 0x11 MUL, 0x12 AND, 0x13 EXE, 0x14 SUB, 0x15 OR, 0x16 CE, 0x17 CLR, others invalid
- key_press  in  1  select button, level; block edge-detects internally
- hex_mode  in  1  1 = hex entry, 0 = decimal entry; latched only at rst/CLR
- restriction  out  1  = ~latched mode (1 in decimal mode)
- display  out  W  value to show
- state  out  2  0 OPA, 1 OPB, 2 RES
- op_pend  out  3  stored operator: 0 none, 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR
- result_valid  out  1  one-cycle pulse when a result is registered
- ovf  out  1  overflow flag (see Optional Feature)

Behaviour:
- Reset: state=OPA; A=B=0; digit counters=0; op_pend=0; display=0; result_valid=0; ovf=0; mode latched from hex_mode; key_press history register=0.
- Key event: key_press is 1 and was 0 the previous cycle. key_val is sampled in the same cycle.
  - Event state update completes at the next edge.
  - Holding key_press high produces no further events.
- Invalid codes (0x18–0x1F) are ignored.
- In decimal mode, digits 0xA–0xF are ignored.
- Digit entry
  - Target operand: A in OPA, B in OPB.
  - Hex mode: X = {X[W-5:0], d}.
  - Decimal mode: X = X*10 + d.
  - A digit is ignored when that operand's counter == NDIG; otherwise the counter increments.
  - A leading 0 still counts as a digit.
- OPA
  - digit → append to A.
  - operator → store op, go to OPB, B=0, B counter=0.
  - EXE → ignored.
- OPB
  - digit → append to B.
  - operator with B counter==0 → replace op only.
  - operator with B counter>0 → chain: A = A op B, result_valid pulse, store new op, B cleared, stay in OPB.
  - EXE with B counter==0 → ignored.
  - EXE with B counter>0 → R = A op B, go to RES, result_valid pulse.
- RES
  - digit → A = that digit (counter=1), op cleared, go to OPA.
  - operator → A = R, store op, go to OPB.
  - EXE → ignored.
- Arithmetic: all modulo 2^W.
  - SUB = A - B, wraps (3 - 5 = 0xFFFE).
  - MUL keeps the low W bits.
  - AND/OR are bitwise.
  - Results are registered (one-cycle latency from the event edge).
- CE
  - OPA: clears A and its counter.
  - OPB: clears B and its counter; op kept.
  - RES: clears to OPA with A=0.
- CLR: full reset-equivalent, including re-latching hex_mode.
- display:
  - OPA → A.
  - OPB with B counter==0 → A.
  - OPB with B counter>0 → B.
  - RES → R.
- rst mid-entry overrides any event in the same cycle.

Optional Feature:
- Macro: CALC_OVF_FLAG_EN.
- Defined:
  - ovf is registered alongside every computed result (chain or EXE).
  - ovf=1 on ADD carry out, SUB borrow (A<B), or MUL upper W bits nonzero; otherwise 0.
  - ovf is held until the next computation, CE, CLR, or rst.
- Undefined: ovf is tied to 0.

Test Plan:
- rst, hex_mode=1; press 0x1, 0x2, ADD, 0x3, EXE → display 0x0012 → 0x0012 (OPB, B empty) → 0x0003 → 0x0015, result_valid single pulse, state=2.
- hex_mode=0, CLR; press 9 five times → display 9999 (0x270F), fifth press ignored; press 0xB → ignored, restriction=1.
- Continuing: MUL, 9, EXE → display 0x5F87 (89991 mod 65536); ovf=1 if CALC_OVF_FLAG_EN, else 0.
- Hex: 3, SUB, 5, EXE → 0xFFFE, ovf=1 with macro. Then ADD, 2, EXE → 0x0000 (operator in RES reuses R).
- Chain: 2, ADD, 3, OR → display 0x0005, op_pend=5, result_valid pulse. Then 8, EXE → 0x000D.
- key_press held high for 10 cycles on 0x7 → A=0x7 exactly once. Then CE → 0. Then 4, rst asserted in the same cycle as the event → display 0, state 0.

Source files
------------

// File: rtl/calc_key_entry.sv
// rtl/calc_key_entry.sv - keypad calculator core: operand entry, operator latch, compute on EXE
// Optional overflow flag enabled by defining CALC_OVF_FLAG_EN.
module calc_key_entry #(
  parameter int NDIG = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          key_val,
  input  logic                key_press,
  input  logic                hex_mode,
  output logic                restriction,
  output logic [4*NDIG-1:0]   display,
  output logic [1:0]          state,
  output logic [2:0]          op_pend,
  output logic                result_valid,
  output logic                ovf
);

  localparam int W  = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    S_OPA = 2'd0,
    S_OPB = 2'd1,
    S_RES = 2'd2
  } st_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;

  st_t            cur_st, nxt_st;
  logic [W-1:0]   a_q, a_n, b_q, b_n, r_q, r_n;
  logic [CW-1:0]  ac_q, ac_n, bc_q, bc_n;
  logic [2:0]     op_q, op_n;
  logic           mode_q, mode_n;
  logic           rv_q, rv_n;
  logic           ovf_q, ovf_n;
  logic           kp_q;

  logic           key_evt;
  logic [3:0]     dig;
  logic           digit_ok;
  logic           is_op, is_exe, is_ce, is_clr;
  logic [2:0]     key_op;
  logic           a_room, b_room;

  logic [W-1:0]   add_res, sub_res, mul_res, alu_res;
  logic           add_of, sub_of, mul_of, alu_of;

  function automatic logic [W-1:0] append_digit(input logic [W-1:0] x, input logic [3:0] d,
                                                input logic hex);
    logic [W-1:0] dz;
    dz = {{(W-4){1'b0}}, d};
    if (hex)
      append_digit = {x[W-5:0], d};
    else
      append_digit = (x << 3) + (x << 1) + dz;
  endfunction

  assign key_evt  = key_press & ~kp_q;
  assign dig      = key_val[3:0];
  assign digit_ok = ~key_val[4] & (mode_q | (dig < 4'd10));
  assign is_exe   = (key_val == 5'h13);
  assign is_ce    = (key_val == 5'h16);
  assign is_clr   = (key_val == 5'h17);
  assign a_room   = (ac_q != CW'(NDIG));
  assign b_room   = (bc_q != CW'(NDIG));

  always_comb begin
    key_op = OP_NONE;
    is_op  = 1'b1;
    case (key_val)
      5'h10:   key_op = OP_ADD;
      5'h11:   key_op = OP_MUL;
      5'h12:   key_op = OP_AND;
      5'h14:   key_op = OP_SUB;
      5'h15:   key_op = OP_OR;
      default: is_op  = 1'b0;
    endcase
  end

  assign sub_res = a_q - b_q;

`ifdef CALC_OVF_FLAG_EN
  logic [W:0]     sum_w;
  logic [2*W-1:0] prod_w;
  assign sum_w   = {1'b0, a_q} + {1'b0, b_q};
  assign prod_w  = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
  assign add_res = sum_w[W-1:0];
  assign add_of  = sum_w[W];
  assign mul_res = prod_w[W-1:0];
  assign mul_of  = |prod_w[2*W-1:W];
  assign sub_of  = (a_q < b_q);
`else
  assign add_res = a_q + b_q;
  assign mul_res = a_q * b_q;
  assign add_of  = 1'b0;
  assign mul_of  = 1'b0;
  assign sub_of  = 1'b0;
`endif

  always_comb begin
    alu_res = a_q;
    alu_of  = 1'b0;
    case (op_q)
      OP_ADD: begin alu_res = add_res; alu_of = add_of; end
      OP_SUB: begin alu_res = sub_res; alu_of = sub_of; end
      OP_MUL: begin alu_res = mul_res; alu_of = mul_of; end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      default: ;
    endcase
  end

  // Next-state and datapath update; everything holds unless a key event arrives.
  always_comb begin
    nxt_st = cur_st;
    a_n    = a_q;
    b_n    = b_q;
    r_n    = r_q;
    ac_n   = ac_q;
    bc_n   = bc_q;
    op_n   = op_q;
    mode_n = mode_q;
    rv_n   = 1'b0;
    ovf_n  = ovf_q;
    if (key_evt) begin
      if (is_clr) begin
        nxt_st = S_OPA;
        a_n    = '0;
        b_n    = '0;
        r_n    = '0;
        ac_n   = '0;
        bc_n   = '0;
        op_n   = OP_NONE;
        mode_n = hex_mode;
        ovf_n  = 1'b0;
      end else if (is_ce) begin
        ovf_n = 1'b0;
        case (cur_st)
          S_OPA: begin a_n = '0; ac_n = '0; end
          S_OPB: begin b_n = '0; bc_n = '0; end
          default: begin
            nxt_st = S_OPA;
            a_n    = '0;
            ac_n   = '0;
            op_n   = OP_NONE;
          end
        endcase
      end else if (digit_ok) begin
        case (cur_st)
          S_OPA: if (a_room) begin
            a_n  = append_digit(a_q, dig, mode_q);
            ac_n = ac_q + 1'b1;
          end
          S_OPB: if (b_room) begin
            b_n  = append_digit(b_q, dig, mode_q);
            bc_n = bc_q + 1'b1;
          end
          default: begin
            nxt_st = S_OPA;
            a_n    = {{(W-4){1'b0}}, dig};
            ac_n   = CW'(1);
            op_n   = OP_NONE;
          end
        endcase
      end else if (is_op) begin
        op_n = key_op;
        case (cur_st)
          S_OPA: begin
            nxt_st = S_OPB;
            b_n    = '0;
            bc_n   = '0;
          end
          S_OPB: if (bc_q != '0) begin
            // Chained operator: fold the pending result into A and keep entering B.
            a_n   = alu_res;
            r_n   = alu_res;
            rv_n  = 1'b1;
            ovf_n = alu_of;
            b_n   = '0;
            bc_n  = '0;
          end
          default: begin
            nxt_st = S_OPB;
            a_n    = r_q;
            b_n    = '0;
            bc_n   = '0;
          end
        endcase
      end else if (is_exe) begin
        if (cur_st == S_OPB && bc_q != '0) begin
          nxt_st = S_RES;
          r_n    = alu_res;
          rv_n   = 1'b1;
          ovf_n  = alu_of;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_st <= S_OPA;
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      ac_q   <= '0;
      bc_q   <= '0;
      op_q   <= OP_NONE;
      mode_q <= hex_mode;
      rv_q   <= 1'b0;
      ovf_q  <= 1'b0;
      kp_q   <= 1'b0;
    end else begin
      cur_st <= nxt_st;
      a_q    <= a_n;
      b_q    <= b_n;
      r_q    <= r_n;
      ac_q   <= ac_n;
      bc_q   <= bc_n;
      op_q   <= op_n;
      mode_q <= mode_n;
      rv_q   <= rv_n;
      ovf_q  <= ovf_n;
      kp_q   <= key_press;
    end
  end

  always_comb begin
    case (cur_st)
      S_OPB:   display = (bc_q != '0) ? b_q : a_q;
      S_RES:   display = r_q;
      default: display = a_q;
    endcase
  end

  assign state        = cur_st;
  assign op_pend      = op_q;
  assign restriction  = ~mode_q;
  assign result_valid = rv_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_calc_key_entry.sv
// tb/tb_calc_key_entry.sv - directed plus randomized bench for calc_key_entry
// Overflow expectations follow CALC_OVF_FLAG_EN when defined.
module tb_calc_key_entry;

  localparam int NDIG = 4;
  localparam int W    = 4 * NDIG;
  localparam longint MOD = 64'd1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   key_val;
  logic         key_press;
  logic         hex_mode;
  logic         restriction;
  logic [W-1:0] display;
  logic [1:0]   state;
  logic [2:0]   op_pend;
  logic         result_valid;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  // Reference calculator held as plain numbers.
  longint m_a, m_b, m_r;
  int     m_ac, m_bc, m_op, m_st;
  bit     m_mode, m_rv, m_ovf;

  calc_key_entry #(.NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .key_val(key_val), .key_press(key_press), .hex_mode(hex_mode),
    .restriction(restriction), .display(display), .state(state), .op_pend(op_pend),
    .result_valid(result_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_r = 0; m_ac = 0; m_bc = 0; m_op = 0; m_st = 0;
    m_rv = 0; m_ovf = 0; m_mode = hex_mode;
  endtask

  function automatic int op_of_key(input int k);
    case (k)
      'h10: return 1;
      'h14: return 2;
      'h11: return 3;
      'h12: return 4;
      'h15: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic calc(output longint res, output bit of);
    longint full;
    of = 0;
    case (m_op)
      1: begin full = m_a + m_b; of = (full >= MOD); end
      2: begin full = m_a - m_b + MOD; of = (m_a < m_b); end
      3: begin full = m_a * m_b; of = (full >= MOD); end
      4: full = m_a & m_b;
      5: full = m_a | m_b;
      default: full = m_a;
    endcase
    res = full % MOD;
`ifndef CALC_OVF_FLAG_EN
    of = 0;
`endif
  endtask

  task automatic model_key(input int k);
    longint res;
    bit of;
    int op;
    m_rv = 0;
    op = op_of_key(k);
    if (k == 'h17) begin
      model_reset();
    end else if (k == 'h16) begin
      m_ovf = 0;
      if (m_st == 0) begin m_a = 0; m_ac = 0; end
      else if (m_st == 1) begin m_b = 0; m_bc = 0; end
      else begin m_st = 0; m_a = 0; m_ac = 0; m_op = 0; end
    end else if (k < 16) begin
      if (!m_mode && k > 9) return;
      if (m_st == 2) begin
        m_a = k; m_ac = 1; m_op = 0; m_st = 0;
      end else if (m_st == 0 && m_ac < NDIG) begin
        m_a = (m_a * (m_mode ? 16 : 10) + k) % MOD; m_ac++;
      end else if (m_st == 1 && m_bc < NDIG) begin
        m_b = (m_b * (m_mode ? 16 : 10) + k) % MOD; m_bc++;
      end
    end else if (op != 0) begin
      if (m_st == 1 && m_bc > 0) begin
        calc(res, of);
        m_a = res; m_r = res; m_rv = 1; m_ovf = of;
      end else if (m_st == 2) begin
        m_a = m_r;
      end
      m_op = op; m_st = 1; m_b = 0; m_bc = 0;
    end else if (k == 'h13) begin
      if (m_st == 1 && m_bc > 0) begin
        calc(res, of);
        m_r = res; m_rv = 1; m_ovf = of; m_st = 2;
      end
    end
  endtask

  function automatic longint m_display();
    if (m_st == 2) return m_r;
    if (m_st == 1 && m_bc > 0) return m_b;
    return m_a;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".display"}, display, m_display());
    chk({tag, ".state"}, state, m_st);
    chk({tag, ".op_pend"}, op_pend, m_op);
    chk({tag, ".restriction"}, restriction, !m_mode);
    chk({tag, ".ovf"}, ovf, m_ovf);
  endtask

  task automatic press(input logic [4:0] k);
    @(negedge clk);
    key_val = k;
    key_press = 1'b1;
    model_key(k);
    @(negedge clk);
    check_all("evt");
    chk("rv_pulse", result_valid, m_rv);
    key_press = 1'b0;
    @(negedge clk);
    chk("rv_low", result_valid, 0);
    check_all("idle");
  endtask

  initial begin
    rst = 1'b1; hex_mode = 1'b1; key_press = 1'b0; key_val = 5'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    chk("reset.rv", result_valid, 0);

    // Hex entry 12 + 3.
    press(5'h01); press(5'h02); chk("tp1.a", display, 'h12);
    press(5'h10); chk("tp1.opb_empty", display, 'h12);
    press(5'h03); chk("tp1.b", display, 'h3);
    press(5'h13); chk("tp1.res", display, 'h15); chk("tp1.state", state, 2);

    // Decimal digit limit and restricted hex digits.
    hex_mode = 1'b0;
    press(5'h17);
    repeat (5) press(5'h09);
    chk("tp2.9999", display, 'h270F);
    press(5'h0B); chk("tp2.b_ignored", display, 'h270F); chk("tp2.restr", restriction, 1);
    press(5'h11); press(5'h09); press(5'h13);
    chk("tp3.mul", display, 'h5F87);
`ifdef CALC_OVF_FLAG_EN
    chk("tp3.ovf", ovf, 1);
`else
    chk("tp3.ovf", ovf, 0);
`endif

    // Hex subtract wrap, then reuse of R.
    hex_mode = 1'b1;
    press(5'h17);
    press(5'h03); press(5'h14); press(5'h05); press(5'h13);
    chk("tp4.sub", display, 'hFFFE);
    press(5'h10); press(5'h02); press(5'h13);
    chk("tp4.reuse", display, 'h0000);

    // Chained operator.
    press(5'h02); press(5'h10); press(5'h03); press(5'h15);
    chk("tp5.chain", display, 'h5); chk("tp5.op", op_pend, 5);
    press(5'h08); press(5'h13);
    chk("tp5.or", display, 'hD);

    // Held key gives a single event.
    @(negedge clk);
    key_val = 5'h07; key_press = 1'b1;
    model_key(7);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold.display", display, 'h7);
    end
    key_press = 1'b0;
    @(negedge clk);
    check_all("hold");
    press(5'h16);
    chk("ce", display, 0);

    // Reset wins over a simultaneous event.
    @(negedge clk);
    key_val = 5'h04; key_press = 1'b1; rst = 1'b1;
    @(negedge clk);
    model_reset();
    chk("rst_evt.display", display, 0);
    chk("rst_evt.state", state, 0);
    rst = 1'b0; key_press = 1'b0;
    @(negedge clk);
    check_all("rst_evt");

    // Randomized key sequences against the model.
    for (int i = 0; i < 400; i++) begin
      int k;
      hex_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        k = $urandom_range(16, 31);
      else if ($urandom_range(0, 30) == 0)
        k = 'h17;
      else
        k = $urandom_range(0, 15);
      press(5'(k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
